bit_serial_adder: RTL

//  Bit-serial N-bit adder: accepts operands A, B and carry-in Cin over a valid/ready handshake.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/bit_serial_adder.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the serial arithmetic cells.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full adder cell used as the single arithmetic element of the serial adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full_adder, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   SHIFT | one bit step per clock, WIDTH steps total
//   DONE  | result held with out_valid high until out_ready
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s, fa_c;
  logic             last_step;

  full_adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  assign last_step = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so bit 0 lands at Sum[0] after WIDTH steps.
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_step) cout_q <= fa_c;
        end
        default: ;
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule
